axi_dma_rd_if: RTL and testbench

AXI_DMA_RD_IF -- requirements
Module: axi_dma_rd_if

---
 rtl/axi_dma_rd_if_if.sv | 29 ++
 rtl/axi_dma_rd_if.sv | 155 +++++++++++++++
 tb/tb_axi_dma_rd_if.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_dma_rd_if_if.sv
// AR/R channel bundle between the DMA read engine (master) and the AXI fabric (slave).
interface axi_dma_rd_if_if #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 128,
    parameter int ID_W    = 1,
    parameter int BURST_W = 6
);
    logic [ID_W-1:0]    arid;
    logic [ADDR_W-1:0]  araddr;
    logic [BURST_W-1:0] arlen;
    logic               arvalid;
    logic               arready;
    logic [ID_W-1:0]    rid;
    logic [DATA_W-1:0]  rdata;
    logic [1:0]         rresp;
    logic               rlast;
    logic               rvalid;
    logic               rready;

    modport master (
        output arid, araddr, arlen, arvalid, rready,
        input  arready, rid, rdata, rresp, rlast, rvalid
    );

    modport slave (
        input  arid, araddr, arlen, arvalid, rready,
        output arready, rid, rdata, rresp, rlast, rvalid
    );
endinterface

// File: rtl/axi_dma_rd_if.sv
// Splits a {bank,sec,sub}/length descriptor into fixed BURST_LEN-beat AXI reads, one burst in flight.
// AR issued only once the FIFO can take a whole burst; R beats forwarded to the FIFO with no added latency.
module axi_dma_rd_if #(
    parameter int AXI_ADDR_WIDTH  = 32,
    parameter int AXI_DATA_WIDTH  = 128,
    parameter int AXI_ID_WIDTH    = 1,
    parameter int AXI_ID          = 1,
    parameter int AXI_BURST_WIDTH = 6,
    parameter int LEN_WIDTH       = 20,
    parameter int DDR_WIDTH       = 27,
    parameter int BANK_WIDTH      = 3,
    parameter int SEC_WIDTH       = 2,
    parameter int BURST_LEN       = 8,
    parameter int SUB_WIDTH       = LEN_WIDTH,
    parameter int ADDR_WIDTH      = BANK_WIDTH + SEC_WIDTH + SUB_WIDTH
) (
    input  logic                      aclk,
    input  logic                      areset,
    axi_dma_rd_if_if.master           m_axi,
    input  logic [ADDR_WIDTH-1:0]     cfg_desc_addr,
    input  logic [LEN_WIDTH-1:0]      cfg_desc_len,
    input  logic                      cfg_valid,
    output logic                      cfg_ready,
    output logic                      if_wr_push,
    output logic [AXI_DATA_WIDTH-1:0] if_wr_data,
    input  logic                      if_wr_ready,
    output logic                      st_last,
    output logic                      st_err
);
    localparam int SSUB_WIDTH = 3 + $clog2(BURST_LEN);
    localparam int PTR_WIDTH  = SUB_WIDTH - SSUB_WIDTH;
    localparam int REM_WIDTH  = LEN_WIDTH - SSUB_WIDTH;
    localparam int BEAT_WIDTH = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam logic [BEAT_WIDTH-1:0]   LAST_BEAT = BEAT_WIDTH'(BURST_LEN - 1);
    localparam logic [AXI_ID_WIDTH-1:0] MY_ID     = AXI_ID_WIDTH'(AXI_ID);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ADDR,
        S_DATA
    } state_t;

    state_t                  r_state;
    logic                    r_arvalid;
    logic                    r_rready;
    logic                    r_cfg_ready;
    logic                    r_err;
    logic [BEAT_WIDTH-1:0]   r_beat;
    logic [BANK_WIDTH-1:0]   r_bank;
    logic [SEC_WIDTH-1:0]    r_sec;
    logic [PTR_WIDTH-1:0]    r_ptr;
    logic [REM_WIDTH-1:0]    r_rem;

    logic [AXI_ADDR_WIDTH-1:0] w_araddr;
    logic                      w_beat_acc;
    logic                      w_at_last;
    logic                      w_beat_err;
    logic                      w_unused;

    // Sub-granule address/length bits carry no meaning for burst-aligned transfers.
    assign w_unused = ^{cfg_desc_addr[SSUB_WIDTH-1:0], cfg_desc_len[SSUB_WIDTH-1:0]};

    always_comb begin
        w_araddr = '0;
        w_araddr[DDR_WIDTH-1 -: BANK_WIDTH]  = r_bank;
        w_araddr[SUB_WIDTH +: SEC_WIDTH]     = r_sec;
        w_araddr[SUB_WIDTH-1:SSUB_WIDTH]     = r_ptr;
    end

    assign w_beat_acc = (r_state == S_DATA) && r_rready && m_axi.rvalid && (m_axi.rid == MY_ID);
    assign w_at_last  = (r_beat == LAST_BEAT);
    assign w_beat_err = w_beat_acc && ((m_axi.rresp != 2'b00) || (m_axi.rlast != w_at_last));

    assign m_axi.arid    = MY_ID;
    assign m_axi.araddr  = w_araddr;
    assign m_axi.arlen   = AXI_BURST_WIDTH'(BURST_LEN - 1);
    assign m_axi.arvalid = r_arvalid;
    assign m_axi.rready  = r_rready;

    assign cfg_ready  = r_cfg_ready;
    assign if_wr_push = w_beat_acc;
    assign if_wr_data = m_axi.rdata;
    assign st_last    = w_beat_acc && w_at_last && (r_rem == '0);
    assign st_err     = r_err;

    always_ff @(posedge aclk) begin
        if (areset) begin
            r_state     <= S_IDLE;
            r_arvalid   <= 1'b0;
            r_rready    <= 1'b0;
            r_cfg_ready <= 1'b1;
            r_err       <= 1'b0;
            r_beat      <= '0;
            r_bank      <= '0;
            r_sec       <= '0;
            r_ptr       <= '0;
            r_rem       <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (cfg_valid) begin
                        r_bank      <= cfg_desc_addr[ADDR_WIDTH-1 -: BANK_WIDTH];
                        r_sec       <= cfg_desc_addr[SUB_WIDTH +: SEC_WIDTH];
                        r_ptr       <= cfg_desc_addr[SUB_WIDTH-1:SSUB_WIDTH];
                        r_rem       <= cfg_desc_len[LEN_WIDTH-1:SSUB_WIDTH];
                        r_err       <= 1'b0;
                        r_cfg_ready <= 1'b0;
                        r_state     <= S_ADDR;
                    end
                end
                S_ADDR: begin
                    // Once raised, arvalid holds regardless of later FIFO room changes.
                    if (r_arvalid) begin
                        if (m_axi.arready) begin
                            r_arvalid <= 1'b0;
                            r_rready  <= 1'b1;
                            r_beat    <= '0;
                            r_state   <= S_DATA;
                        end
                    end else if (if_wr_ready) begin
                        r_arvalid <= 1'b1;
                    end
                end
                S_DATA: begin
                    if (w_beat_err) begin
                        r_err <= 1'b1;
                    end
                    if (w_beat_acc) begin
                        if (w_at_last) begin
                            r_beat   <= '0;
                            r_rready <= 1'b0;
                            if (r_rem == '0) begin
                                r_state     <= S_IDLE;
                                r_cfg_ready <= 1'b1;
                            end else begin
                                // Pointer wraps inside the section; bank/sec never change mid-transfer.
                                r_ptr   <= r_ptr + PTR_WIDTH'(1);
                                r_rem   <= r_rem - REM_WIDTH'(1);
                                r_state <= S_ADDR;
                            end
                        end else begin
                            r_beat <= r_beat + BEAT_WIDTH'(1);
                        end
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_arvalid   <= 1'b0;
                    r_rready    <= 1'b0;
                    r_cfg_ready <= 1'b1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_axi_dma_rd_if.sv
// Directed + randomized bench for axi_dma_rd_if with an address/beat reference model.
module tb_axi_dma_rd_if;
    logic         aclk = 1'b0;
    logic         areset;
    logic [24:0]  cfg_desc_addr;
    logic [19:0]  cfg_desc_len;
    logic         cfg_valid;
    logic         cfg_ready;
    logic         if_wr_push;
    logic [127:0] if_wr_data;
    logic         if_wr_ready;
    logic         st_last;
    logic         st_err;

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;
    logic [31:0] ar_log[$];

    axi_dma_rd_if_if axi ();

    axi_dma_rd_if dut (
        .aclk          (aclk),
        .areset        (areset),
        .m_axi         (axi),
        .cfg_desc_addr (cfg_desc_addr),
        .cfg_desc_len  (cfg_desc_len),
        .cfg_valid     (cfg_valid),
        .cfg_ready     (cfg_ready),
        .if_wr_push    (if_wr_push),
        .if_wr_data    (if_wr_data),
        .if_wr_ready   (if_wr_ready),
        .st_last       (st_last),
        .st_err        (st_err)
    );

    always #5 aclk = ~aclk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, observed hang expected completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Burst k of a descriptor: bank<<24 | sec<<20 | ((start granule + k) mod 2^14) << 6.
    function automatic logic [31:0] exp_addr(input logic [24:0] a, input int k);
        int unsigned bank, sec, ptr;
        bank = a[24:22];
        sec  = a[21:20];
        ptr  = (int'(a[19:6]) + k) % 16384;
        return 32'((bank << 24) | (sec << 20) | (ptr << 6));
    endfunction

    task automatic run_xfer(input logic [24:0] a, input logic [19:0] l, input int wr_hold,
                            input int ar_hold, input int err_mode, input bit rnd, input int abort_at);
        int nbursts, bursts_ar, beat, lasts, viol, cyc, ar_wait, nmatch;
        bit in_addr, exp_arv, outstanding, exp_err, done, aborted, exp_push, exp_last;
        logic [127:0] expq[$];
        logic [127:0] gotq[$];
        nbursts = int'(l[19:6]) + 1;
        bursts_ar = 0; beat = 0; lasts = 0; viol = 0; cyc = 0; ar_wait = 0; nmatch = 0;
        in_addr = 0; exp_arv = 0; outstanding = 0; exp_err = 0; done = 0; aborted = 0;
        ar_log.delete();

        cfg_desc_addr = a;
        cfg_desc_len  = l;
        cfg_valid     = 1'b1;
        @(negedge aclk);
        chk("cfg_ready_idle", cfg_ready, 1'b1);
        @(posedge aclk); #1;
        cfg_valid     = 1'b0;
        cfg_desc_addr = 25'($urandom);
        cfg_desc_len  = 20'($urandom);
        in_addr       = 1'b1;

        while (!done && !aborted && cyc < 3000) begin
            if_wr_ready = (cyc < wr_hold) ? 1'b0 : (rnd ? ($urandom_range(0, 3) != 0) : 1'b1);
            axi.arready = (bursts_ar == 0 && ar_wait < ar_hold) ? 1'b0 :
                          (rnd ? 1'($urandom_range(0, 1)) : 1'b1);
            cfg_valid   = rnd && ($urandom_range(0, 7) == 0);
            axi.rvalid  = 1'b0;
            axi.rid     = 1'b1;
            axi.rresp   = 2'b00;
            axi.rlast   = 1'b0;
            axi.rdata   = {$urandom, $urandom, $urandom, $urandom};
            if (outstanding) begin
                if (rnd && $urandom_range(0, 3) == 0) begin
                    axi.rvalid = 1'b0;
                end else if (rnd && $urandom_range(0, 4) == 0) begin
                    axi.rvalid = 1'b1;
                    axi.rid    = 1'b0;
                    axi.rresp  = 2'($urandom);
                    axi.rlast  = 1'($urandom);
                end else begin
                    axi.rvalid = 1'b1;
                    axi.rlast  = (beat == 7) || (err_mode == 2 && bursts_ar == 1 && beat == 4);
                    axi.rresp  = (err_mode == 1 && bursts_ar == 1 && beat == 2) ? 2'b10 : 2'b00;
                end
            end else if (rnd) begin
                axi.rvalid = 1'($urandom_range(0, 1));
            end

            @(negedge aclk);
            if (cyc == 0) chk("err_clear_on_accept", st_err, 1'b0);
            exp_push = outstanding && axi.rvalid && (axi.rid == 1'b1);
            exp_last = exp_push && (beat == 7) && (bursts_ar == nbursts);
            if (axi.arvalid !== exp_arv) viol++;
            if (exp_arv && axi.araddr !== exp_addr(a, bursts_ar)) viol++;
            if (axi.rready !== outstanding) viol++;
            if (cfg_ready !== 1'b0) viol++;
            if (if_wr_push !== exp_push) viol++;
            if (st_last !== exp_last) viol++;
            if (st_last === 1'b1) lasts++;
            if (if_wr_push === 1'b1) gotq.push_back(if_wr_data);
            if (exp_push) begin
                expq.push_back(axi.rdata);
                nmatch++;
                if (axi.rresp != 2'b00 || axi.rlast != (beat == 7)) exp_err = 1'b1;
            end
            if (exp_arv && axi.arready) begin
                ar_log.push_back(axi.araddr);
                chk($sformatf("araddr_b%0d", bursts_ar), axi.araddr, exp_addr(a, bursts_ar));
                chk("arlen", axi.arlen, 6'd7);
                chk("arid", axi.arid, 1'b1);
            end
            if (exp_arv && !axi.arready) ar_wait++;

            if (abort_at > 0 && nmatch == abort_at) begin
                aborted = 1'b1;
            end else begin
                @(posedge aclk); #1;
                if (exp_arv && axi.arready) begin
                    exp_arv = 1'b0; in_addr = 1'b0; outstanding = 1'b1; beat = 0; bursts_ar++;
                end else if (in_addr) begin
                    exp_arv = exp_arv || if_wr_ready;
                end
                if (exp_push) begin
                    if (beat == 7) begin
                        outstanding = 1'b0;
                        if (bursts_ar == nbursts) done = 1'b1;
                        else in_addr = 1'b1;
                    end else begin
                        beat++;
                    end
                end
                cyc++;
            end
        end

        cfg_valid   = 1'b0;
        axi.rvalid  = 1'b0;
        axi.arready = 1'b0;
        if_wr_ready = 1'b1;
        if (!aborted) begin
            chk("xfer_done", done, 1'b1);
            chk("ar_count", bursts_ar, nbursts);
            chk("push_count", gotq.size(), expq.size());
            for (int i = 0; i < expq.size() && i < gotq.size(); i++)
                chk($sformatf("push_data_%0d", i), gotq[i], expq[i]);
            chk("st_last_count", lasts, 1);
            chk("protocol", viol, 0);
            @(negedge aclk);
            chk("cfg_ready_after", cfg_ready, 1'b1);
            chk("st_err_end", st_err, exp_err);
            repeat (3) @(negedge aclk);
            chk("st_err_sticky", st_err, exp_err);
            @(posedge aclk); #1;
        end else begin
            chk("protocol_pre_abort", viol, 0);
        end
    endtask

    initial begin
        int stray;
        areset        = 1'b1;
        cfg_valid     = 1'b0;
        cfg_desc_addr = '0;
        cfg_desc_len  = '0;
        if_wr_ready   = 1'b1;
        axi.arready   = 1'b0;
        axi.rid       = 1'b0;
        axi.rdata     = '0;
        axi.rresp     = 2'b00;
        axi.rlast     = 1'b0;
        axi.rvalid    = 1'b0;
        repeat (3) @(posedge aclk);
        @(negedge aclk);
        chk("rst_arvalid", axi.arvalid, 1'b0);
        chk("rst_rready", axi.rready, 1'b0);
        chk("rst_push", if_wr_push, 1'b0);
        chk("rst_st_last", st_last, 1'b0);
        chk("rst_st_err", st_err, 1'b0);
        chk("rst_cfg_ready", cfg_ready, 1'b1);
        @(posedge aclk); #1;
        areset = 1'b0;

        // Two-burst reference transfer.
        run_xfer({3'd2, 2'd1, 20'h00040}, 20'h0007F, 0, 0, 0, 1'b0, 0);
        chk("ref_addr0", ar_log[0], 32'h0210_0040);
        chk("ref_addr1", ar_log[1], 32'h0210_0080);

        // FIFO room withheld, then AR stalled by the slave.
        run_xfer({3'd1, 2'd3, 20'h12340}, 20'h0003F, 10, 0, 0, 1'b0, 0);
        run_xfer({3'd6, 2'd0, 20'h00A00}, 20'h000BF, 0, 5, 0, 1'b0, 0);

        // Pointer wrap at top of the sub field.
        run_xfer({3'd5, 2'd2, 20'hFFFC0}, 20'h0007F, 0, 0, 0, 1'b0, 0);
        chk("wrap_addr0", ar_log[0], 32'h052F_FFC0);
        chk("wrap_addr1", ar_log[1], 32'h0520_0000);

        // Error reporting: bad rresp on beat 3, early rlast on beat 5.
        run_xfer({3'd0, 2'd1, 20'h00100}, 20'h00000, 0, 0, 1, 1'b0, 0);
        run_xfer({3'd3, 2'd2, 20'h00200}, 20'h00000, 0, 0, 2, 1'b0, 0);
        run_xfer({3'd7, 2'd0, 20'h00300}, 20'h00000, 0, 0, 0, 1'b0, 0);

        // Reset in the middle of a burst.
        run_xfer({3'd4, 2'd1, 20'h00400}, 20'h0003F, 0, 0, 1, 1'b0, 4);
        chk("err_before_reset", st_err, 1'b1);
        areset     = 1'b1;
        axi.rvalid = 1'b1;
        axi.rid    = 1'b1;
        axi.rlast  = 1'b0;
        @(posedge aclk); #1;
        areset = 1'b0;
        @(negedge aclk);
        chk("mid_rst_arvalid", axi.arvalid, 1'b0);
        chk("mid_rst_rready", axi.rready, 1'b0);
        chk("mid_rst_push", if_wr_push, 1'b0);
        chk("mid_rst_st_last", st_last, 1'b0);
        chk("mid_rst_st_err", st_err, 1'b0);
        chk("mid_rst_cfg_ready", cfg_ready, 1'b1);
        stray = 0;
        repeat (5) begin
            @(negedge aclk);
            if (if_wr_push !== 1'b0) stray++;
        end
        chk("no_push_after_reset", stray, 0);
        @(posedge aclk); #1;
        axi.rvalid = 1'b0;
        run_xfer({3'd4, 2'd1, 20'h00400}, 20'h0007F, 0, 0, 0, 1'b0, 0);

        // Randomized descriptors, handshakes, foreign-ID beats and errors.
        for (int t = 0; t < 8; t++) begin
            run_xfer(25'($urandom), 20'($urandom_range(0, 255)), $urandom_range(0, 3),
                     $urandom_range(0, 3), $urandom_range(0, 2), 1'b1, 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
